// File: rtl/soc_pmem_loader_pkg.sv
// rtl/soc_pmem_loader_pkg.sv - State encoding and RAM write-enable constants for soc_pmem_loader
package soc_pmem_loader_pkg;

  localparam logic [1:0] WE_NONE = 2'b00;
  localparam logic [1:0] WE_WORD = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    GET_LO,
    GET_HI,
    WRITE,
`ifdef SOC_PMEM_LOADER_VERIFY_EN
    VRD,
    VCMP,
`endif
    DONE
  } state_t;

endpackage

// File: rtl/soc_pmem_loader.sv
// rtl/soc_pmem_loader.sv - Byte-stream to 16-bit program-memory loader on the spare RAM port
// Optional read-back verify of every word: define SOC_PMEM_LOADER_VERIFY_EN.
module soc_pmem_loader
  import soc_pmem_loader_pkg::*;
#(
  parameter int                ADDR_MSB  = 11,
  parameter logic [ADDR_MSB:0] BASE_ADDR = '0
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              start,
  input  logic [ADDR_MSB:0] length,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              ram_en,
  output logic [1:0]        ram_we,
  output logic [ADDR_MSB:0] ram_addr,
  output logic [15:0]       ram_din,
  input  logic [15:0]       ram_dout,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_MSB:0] word_cnt
);

  localparam int AW = ADDR_MSB + 1;

  state_t            state;
  state_t            next_state;
  logic [ADDR_MSB:0] length_q;
  logic [ADDR_MSB:0] cnt_next;
  logic [7:0]        lo_byte;
  logic              xfer;
  logic              last_word;
  logic              step;

  assign xfer      = s_valid && s_ready;
  assign cnt_next  = word_cnt + AW'(1);
  assign last_word = (cnt_next == length_q);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_comb begin
    next_state = state;
    s_ready    = 1'b0;
    ram_en     = 1'b0;
    ram_we     = WE_NONE;
    step       = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next_state = (length == '0) ? DONE : GET_LO;
      end
      GET_LO: begin
        s_ready = 1'b1;
        if (s_valid) next_state = GET_HI;
      end
      GET_HI: begin
        s_ready = 1'b1;
        if (s_valid) next_state = WRITE;
      end
      WRITE: begin
        ram_en = 1'b1;
        ram_we = WE_WORD;
`ifdef SOC_PMEM_LOADER_VERIFY_EN
        next_state = VRD;
`else
        step       = 1'b1;
        next_state = last_word ? DONE : GET_LO;
`endif
      end
`ifdef SOC_PMEM_LOADER_VERIFY_EN
      VRD: begin
        ram_en     = 1'b1;
        next_state = VCMP;
      end
      VCMP: begin
        step       = 1'b1;
        next_state = last_word ? DONE : GET_LO;
      end
`endif
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // ram_addr/ram_din are loaded as the high byte arrives so they are stable for WRITE and hold afterwards
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      state    <= IDLE;
      length_q <= '0;
      word_cnt <= '0;
      lo_byte  <= '0;
      ram_addr <= '0;
      ram_din  <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && start) begin
        length_q <= length;
        word_cnt <= '0;
      end
      if (state == GET_LO && xfer) lo_byte <= s_data;
      if (state == GET_HI && xfer) begin
        ram_addr <= BASE_ADDR + word_cnt;
        ram_din  <= {s_data, lo_byte};
      end
      if (step) word_cnt <= cnt_next;
    end
  end

`ifdef SOC_PMEM_LOADER_VERIFY_EN
  logic error_q;

  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      error_q <= 1'b0;
    end else if (state == IDLE && start) begin
      error_q <= 1'b0;
    end else if (state == VCMP && ram_dout != ram_din) begin
      error_q <= 1'b1;
    end
  end

  assign error = error_q;
`else
  logic unused_dout;
  assign unused_dout = ^ram_dout;
  assign error       = 1'b0;
`endif

endmodule

// File: tb/tb_soc_pmem_loader.sv
// tb/tb_soc_pmem_loader.sv - Self-checking bench for soc_pmem_loader (two instances, bases 0x000 and 0xFFE)
module tb_soc_pmem_loader;

`ifdef SOC_PMEM_LOADER_VERIFY_EN
  localparam int WCYC        = 5;
  localparam int EN_PER_WORD = 2;
  localparam bit VERIFY_ON   = 1'b1;
`else
  localparam int WCYC        = 3;
  localparam int EN_PER_WORD = 1;
  localparam bit VERIFY_ON   = 1'b0;
`endif

  logic        mclk;
  logic        puc_rst;
  logic        start;
  logic [11:0] length;
  logic [7:0]  s_data;
  logic        s_valid;

  logic        s_ready_o  [2];
  logic        ram_en_o   [2];
  logic [1:0]  ram_we_o   [2];
  logic [11:0] ram_addr_o [2];
  logic [15:0] ram_din_o  [2];
  logic [15:0] ram_dout_i [2];
  logic        busy_o     [2];
  logic        done_o     [2];
  logic        error_o    [2];
  logic [11:0] cnt_o      [2];

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic [7:0]  bytes_q [$];
  logic [27:0] expq [2][$];
  logic [27:0] wlog [2][$];
  logic [27:0] exp_w;
  logic [15:0] mem [2][4096];
  logic [11:0] exp_len;
  int          exp_en;
  bit          exp_err;
  bit          corrupt;
  int          en_cnt    [2];
  int          done_cnt  [2];
  int          done_cyc  [2];
  bit          prev_done [2];
  bit          prev_wr   [2];
  logic [11:0] prev_addr [2];

  soc_pmem_loader #(.ADDR_MSB(11), .BASE_ADDR(12'h000)) dut0 (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_o[0]),
    .ram_en(ram_en_o[0]), .ram_we(ram_we_o[0]), .ram_addr(ram_addr_o[0]),
    .ram_din(ram_din_o[0]), .ram_dout(ram_dout_i[0]), .busy(busy_o[0]),
    .done(done_o[0]), .error(error_o[0]), .word_cnt(cnt_o[0])
  );

  soc_pmem_loader #(.ADDR_MSB(11), .BASE_ADDR(12'hFFE)) dut1 (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .length(length),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_o[1]),
    .ram_en(ram_en_o[1]), .ram_we(ram_we_o[1]), .ram_addr(ram_addr_o[1]),
    .ram_din(ram_din_o[1]), .ram_dout(ram_dout_i[1]), .busy(busy_o[1]),
    .done(done_o[1]), .error(error_o[1]), .word_cnt(cnt_o[1])
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;
  always @(posedge mclk) cyc <= cyc + 1;

  function automatic logic [11:0] base_of(input int d);
    return (d == 1) ? 12'hFFE : 12'h000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // RAM model per instance; the read of word 1 is corrupted when requested
  always @(posedge mclk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_en_o[d]) begin
        if (ram_we_o[d] == 2'b11) mem[d][ram_addr_o[d]] <= ram_din_o[d];
        else ram_dout_i[d] <= mem[d][ram_addr_o[d]] ^
               ((corrupt && ram_addr_o[d] == base_of(d) + 12'd1) ? 16'h8000 : 16'h0000);
      end
    end
  end

  always @(negedge mclk) begin
    for (int d = 0; d < 2; d++) begin
      if (puc_rst) begin
        check("reset_outputs", {s_ready_o[d], ram_en_o[d], ram_we_o[d], ram_addr_o[d], ram_din_o[d],
                                busy_o[d], done_o[d], error_o[d], cnt_o[d]}, 64'd0);
        prev_done[d] = 1'b0;
        prev_wr[d]   = 1'b0;
      end else begin
        if (ram_en_o[d] && ram_we_o[d] == 2'b11) begin
          en_cnt[d]++;
          wlog[d].push_back({ram_addr_o[d], ram_din_o[d]});
          if (expq[d].size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            exp_w = expq[d].pop_front();
            check("write_addr", ram_addr_o[d], exp_w[27:16]);
            check("write_data", ram_din_o[d], exp_w[15:0]);
          end
          prev_wr[d]   = 1'b1;
          prev_addr[d] = ram_addr_o[d];
        end else if (ram_en_o[d]) begin
          en_cnt[d]++;
          check("read_cycle", {prev_wr[d], 1'b1, ram_we_o[d]}, {1'b1, VERIFY_ON, 2'b00});
          check("read_addr", ram_addr_o[d], prev_addr[d]);
          prev_wr[d] = 1'b0;
        end else begin
          check("we_without_en", ram_we_o[d], 2'b00);
          prev_wr[d] = 1'b0;
        end
        check("ready_vs_en", s_ready_o[d] & ram_en_o[d], 0);
        if (!busy_o[d]) check("idle_quiet", {s_ready_o[d], ram_en_o[d], done_o[d]}, 0);
        if (prev_done[d]) check("after_done", {busy_o[d], done_o[d], error_o[d]}, {2'b00, exp_err});
        if (done_o[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
          check("done_busy", busy_o[d], 1);
          check("done_word_cnt", cnt_o[d], exp_len);
          check("done_error", error_o[d], exp_err);
          check("done_writes_left", expq[d].size(), 0);
          check("done_en_cycles", en_cnt[d], exp_en);
        end
        prev_done[d] = done_o[d];
      end
    end
  end

  // Runs one load from the bytes in bytes_q; returns start-to-done latency in cycles
  task automatic do_load(input int len, input bit stall, input bit poke, input bit corr, output int lat);
    int idx;
    int iter;
    int start_c;
    int seen;
    @(posedge mclk); #1;
    corrupt = corr;
    exp_len = len[11:0];
    exp_en  = len * EN_PER_WORD;
    exp_err = VERIFY_ON && corr && (len >= 2);
    for (int d = 0; d < 2; d++) begin
      expq[d].delete();
      wlog[d].delete();
      en_cnt[d] = 0;
      for (int k = 0; k < len; k++)
        expq[d].push_back({base_of(d) + 12'(k), bytes_q[2*k+1], bytes_q[2*k]});
    end
    seen   = done_cnt[0];
    start  = 1'b1;
    length = len[11:0];
    @(posedge mclk); #1;
    start   = 1'b0;
    length  = 12'h5A5;
    start_c = cyc;
    check("busy_after_start", busy_o[0], 1);
    check("error_cleared", error_o[0], 0);
    check("cnt_cleared", cnt_o[0], 0);
    idx  = 0;
    iter = 0;
    while (done_cnt[0] == seen && iter < 400) begin
      if (idx < 2 * len) begin
        s_valid = !stall || iter[0];
        s_data  = bytes_q[idx];
      end else begin
        s_valid = 1'b0;
      end
      start = poke && (iter == 3 || done_o[0]);
      if (s_valid && s_ready_o[0]) idx++;
      @(posedge mclk); #1;
      iter++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    if (done_cnt[0] == seen) check("done_timeout", 0, 1);
    lat = done_cyc[0] - start_c;
  endtask

  initial begin
    int lat;
    puc_rst = 1'b1;
    start   = 1'b0;
    length  = '0;
    s_data  = '0;
    s_valid = 1'b0;
    corrupt = 1'b0;
    exp_len = '0;
    exp_en  = 0;
    exp_err = 1'b0;
    for (int d = 0; d < 2; d++) begin
      en_cnt[d] = 0; done_cnt[d] = 0; done_cyc[d] = 0;
      prev_done[d] = 1'b0; prev_wr[d] = 1'b0; prev_addr[d] = '0;
    end
    repeat (3) @(posedge mclk);
    #1 puc_rst = 1'b0;
    check("reset_state", {busy_o[0], cnt_o[0], ram_addr_o[0], ram_din_o[0], error_o[0], s_ready_o[0]}, 0);

    // Continuous stream, two words
    bytes_q = '{8'h34, 8'h12, 8'h78, 8'h56};
    do_load(2, 1'b0, 1'b0, 1'b0, lat);
    check("t1_latency", lat, 2 * WCYC);
    check("t1_nwrites", wlog[0].size(), 2);
    if (wlog[0].size() == 2) begin
      check("t1_w0", wlog[0][0], 28'h000_1234);
      check("t1_w1", wlog[0][1], 28'h001_5678);
    end
    check("t1_final_cnt", cnt_o[0], 12'd2);

    // Same data, s_valid toggling every other cycle
    do_load(2, 1'b1, 1'b0, 1'b0, lat);
    check("t2_slower", lat > 2 * WCYC, 1);
    check("t2_nwrites", wlog[0].size(), 2);

    // Empty load
    bytes_q = '{};
    do_load(0, 1'b0, 1'b0, 1'b0, lat);
    check("t3_latency", lat, 0);
    check("t3_nwrites", wlog[0].size() + wlog[1].size(), 0);

    // Three words, wraps on the 0xFFE instance; extra starts mid-load and at done are ignored
    bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    do_load(3, 1'b0, 1'b1, 1'b0, lat);
    check("t4_latency", lat, 3 * WCYC);
    check("t4_nwrites", wlog[1].size(), 3);
    if (wlog[1].size() == 3) begin
      check("t4_w0", wlog[1][0], 28'hFFE_0201);
      check("t4_w1", wlog[1][1], 28'hFFF_0403);
      check("t4_w2", wlog[1][2], 28'h000_0605);
    end

    // Reset while the low byte is held
    @(posedge mclk); #1;
    start  = 1'b1;
    length = 12'd2;
    @(posedge mclk); #1;
    start   = 1'b0;
    s_valid = 1'b1;
    s_data  = 8'hEE;
    @(posedge mclk); #1;
    s_valid = 1'b0;
    check("t5_in_get_hi", {busy_o[0], s_ready_o[0]}, 2'b11);
    puc_rst = 1'b1;
    #1;
    check("t5_async_reset", {busy_o[0], s_ready_o[0], ram_en_o[0], cnt_o[0], ram_din_o[0]}, 0);
    repeat (2) @(posedge mclk);
    #1 puc_rst = 1'b0;
    bytes_q = '{8'hCD, 8'hAB};
    do_load(1, 1'b0, 1'b0, 1'b0, lat);
    check("t5_nwrites", wlog[0].size(), 1);
    if (wlog[0].size() == 1) check("t5_w0", wlog[0][0], 28'h000_ABCD);
    if (wlog[1].size() == 1) check("t5_w0_b1", wlog[1][0], 28'hFFE_ABCD);

    // Corrupted read-back of word 1, then a clean rerun
    bytes_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    do_load(3, 1'b0, 1'b0, 1'b1, lat);
    repeat (2) @(posedge mclk);
    #1;
    check("t6_error_idle", error_o[0], VERIFY_ON);
    do_load(2, 1'b0, 1'b0, 1'b0, lat);
    check("t6_clean_error", error_o[0], 0);

    repeat (2) @(posedge mclk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/soc_pmem_loader.md
Name: soc_pmem_loader

Overview:
Initiator that drives one port of the dual-port program-memory RAM (active-high enable and byte-write-enable style) and fills it from a byte stream, e.g. a UART or debug-interface download path.
- Takes bytes over a valid/ready stream and assembles little-endian 16-bit words.
- Writes each word to consecutive word addresses, starting at a programmable base.
- Signals completion.
- Sits between the download front-end and the RAM port that the CPU does not use.

Parameters:
ADDR_MSB, 11, MSB of the RAM word address; address width is ADDR_MSB+1.
BASE_ADDR, 0, word address of the first write; the width is ADDR_MSB+1.

Ports:
mclk  input  1  system clock; all logic on its rising edge.
puc_rst  input  1  asynchronous, active-high reset.
start  input  1  single-cycle request to begin a load; ignored while busy=1.
length  input  ADDR_MSB+1  number of 16-bit words to load; sampled on an accepted start.
s_data  input  8  stream byte.
s_valid  input  1  stream byte valid.
s_ready  output  1  loader can accept a byte.
ram_en  output  1  RAM port enable, active high.
ram_we  output  2  RAM byte write enables, active high; bit0 = low byte.
ram_addr  output  ADDR_MSB+1  RAM word address.
ram_din  output  16  RAM write data.
ram_dout  input  16  RAM read data; valid the cycle after a read enable.
busy  output  1  load in progress.
done  output  1  one-cycle pulse at the end of a load.
error  output  1  sticky verify-mismatch flag; cleared by an accepted start.
word_cnt  output  ADDR_MSB+1  words written so far in the current load.

Behaviour:
- Reset: the FSM goes to IDLE. All outputs are 0: s_ready, ram_en, ram_we, ram_addr, ram_din, busy, done, error, word_cnt.
- A partially assembled word is discarded on reset. No RAM access is issued during or after reset.
- FSM states: IDLE, GET_LO, GET_HI, WRITE, [VRD, VCMP], DONE.
- IDLE:
  - On start=1, latch length, clear word_cnt and error, and set busy=1.
  - If length==0, go to DONE; otherwise go to GET_LO.
- Byte transfer: a byte moves when s_valid && s_ready. s_ready=1 only in GET_LO and GET_HI. s_ready is a pure function of state and does not depend on s_valid.
- GET_LO: on a transfer, store the byte as the low byte and go to GET_HI.
- GET_HI: on a transfer, store the byte as the high byte and go to WRITE.
- WRITE (exactly one cycle):
  - Drive ram_en=1, ram_we=2'b11, ram_addr=(BASE_ADDR+word_cnt) mod 2^(ADDR_MSB+1), ram_din={hi,lo}.
  - Next cycle: word_cnt increments. If the new count equals length, go to DONE; otherwise go to GET_LO.
- RAM strobes: ram_en and ram_we are 0 in every state other than WRITE and VRD. ram_addr and ram_din hold their last values.
- DONE: done=1 for exactly one cycle while busy stays 1. Then go to IDLE, where busy=0.
- Throughput: a word takes at least 3 cycles (GET_LO, GET_HI, WRITE) with continuous s_valid. Stalls on s_valid=0 add cycles and produce no spurious writes.
- Address wrap: after the top word address, the next write goes to address 0. word_cnt never wraps, because length ≤ 2^(ADDR_MSB+1)-1.
- Simultaneous events: a start that arrives in the same cycle as done is ignored. Another start is accepted only from IDLE.

Optional Feature:
Macro: SOC_PMEM_LOADER_VERIFY_EN.
- With the macro defined, WRITE goes to VRD instead of doing the count/next-state step itself.
  - VRD: drive ram_en=1, ram_we=2'b00, same ram_addr.
  - VCMP: compare ram_dout against {hi,lo}. A mismatch sets error=1, and error stays set until the next accepted start. Then increment word_cnt and pick the next state as described for WRITE.
  - Throughput becomes at least 5 cycles per word.
- Without the macro: VRD and VCMP do not exist, ram_dout is unused, and error is tied to 0.

Decomposition:
- Package soc_pmem_loader_pkg holds:
  - the state enum typedef;
  - the RAM write-enable constants WE_NONE=2'b00 and WE_WORD=2'b11.
- No sub-module: byte assembly is two registers inside the FSM. Implementation is a single module.

Test Plan:
1. ADDR_MSB=11, BASE_ADDR=0, length=2, bytes 34,12,78,56 with s_valid held at 1 -> writes {addr 0x000, din 0x1234, we 11} then {0x001, 0x5678}; s_ready=0 in write cycles; single done pulse; word_cnt=2; busy falls the cycle after done.
2. Same data with s_valid toggling on alternate cycles -> identical writes, exactly 2 cycles with ram_en=1, no writes while stalled.
3. length=0 -> DONE the cycle after start, done pulse, ram_en never asserted, s_ready never asserted.
4. BASE_ADDR=0xFFE, length=3 -> write addresses 0xFFE, 0xFFF, 0x000 in order.
5. Assert puc_rst after the low byte has been accepted -> all outputs 0, no write; after release, a new load with length=1 and bytes CD,AB writes 0xABCD to BASE_ADDR.
6. With SOC_PMEM_LOADER_VERIFY_EN defined, the RAM model corrupts the read of word 1 -> error=1 at done and still 1 in IDLE; next start clears it; a clean rerun leaves error=0; each word shows a write cycle followed by a read cycle at the same address.
